histogram_core: RTL

- Pixel-statistics engine sitting directly downstream of the histogram_ip AXI4-Lite register bank.
- The register bank drives its start/clear strobes, and this block returns status plus bin-readout data for the bank's read path.
- Pixels arrive on an AXI4-Stream slave; each accepted pixel increments one counter in a 2^PIXEL_W-entry bin RAM.
- Accumulation uses a pipelined read-modify-write with hazard forwarding.

---
 rtl/histogram_pkg.sv | 29 ++
 rtl/hist_bin_ram.sv | 27 ++
 rtl/histogram_core.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/histogram_pkg.sv
// Shared types, default sizes and helpers for the histogram engine.
//   hist_state_t : control FSM states
//   PIXEL_W      : default pixel width (NBINS = 2**PIXEL_W)
//   CNT_W        : default bin / pixel counter width
//   sat_inc()    : increment that holds at the all-ones value of a given width
package histogram_pkg;

  localparam int PIXEL_W   = 8;
  localparam int CNT_W     = 32;
  // Widest counter sat_inc() can handle; callers zero-extend into it.
  localparam int MAX_CNT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } hist_state_t;

  // Saturating increment of a width-bit counter carried in a MAX_CNT_W container.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned           width);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
    return (value >= max_val) ? value : value + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin RAM, 2**ADDR_W x DATA_W.
//   clk   : clock
//   we    : write enable; waddr/wdata : write port
//   raddr : read address; rdata : RAM[raddr] one cycle later (read-first
//           when the same address is written in the same cycle)
module hist_bin_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // defined only after the core has run a CLEAR sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/histogram_core.sv
// Pixel histogram engine behind the histogram_ip register bank.
//   ACLK, ARESETN          : clock, async active-low reset
//   s_axis_*               : pixel stream; tdata selects the bin to increment
//   ctrl_start, ctrl_clear : one-cycle control pulses from the register bank
//   stat_busy/done/pix_cnt : status back to the register bank
//   bin_rd_*               : bin readout, one-cycle latency, IDLE/DONE only
// Accumulation is a 3-stage read-modify-write (S0 read, S1 data, S2 write)
// that never stalls; same-bin hazards are resolved by forwarding.
module histogram_core #(
  parameter int PIXEL_W = histogram_pkg::PIXEL_W,
  parameter int CNT_W   = histogram_pkg::CNT_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [PIXEL_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               ctrl_start,
  input  logic               ctrl_clear,
  output logic               stat_busy,
  output logic               stat_done,
  output logic [CNT_W-1:0]   stat_pix_cnt,
  input  logic               bin_rd_en,
  input  logic [PIXEL_W-1:0] bin_rd_addr,
  output logic [CNT_W-1:0]   bin_rd_data,
  output logic               bin_rd_valid
);

  import histogram_pkg::*;

  localparam int NBINS = 2**PIXEL_W;

  typedef logic [PIXEL_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  hist_state_t state;
  addr_t       clr_addr;
  logic        rd_valid_q;

  // RMW pipeline; S3 remembers the write committed on the previous edge.
  logic  s1_valid, s2_valid, s3_valid;
  addr_t s1_addr, s2_addr, s3_addr;
  cnt_t  s2_data, s3_data;
  cnt_t  s1_base;
  cnt_t  s1_inc;

  logic  beat;
  logic  rd_ok;
  logic  ram_we;
  addr_t ram_waddr;
  addr_t ram_raddr;
  cnt_t  ram_wdata;
  cnt_t  ram_rdata;

  assign beat      = s_axis_tvalid && s_axis_tready;
  assign rd_ok     = (state == ST_IDLE) || (state == ST_DONE);
  assign stat_busy = state inside {ST_CLEAR, ST_ACCUM, ST_DRAIN};

  // The single RAM read port serves bin readout when idle, the pipeline otherwise.
  assign ram_raddr = rd_ok ? bin_rd_addr : s_axis_tdata;

  assign bin_rd_valid = rd_valid_q;
  assign bin_rd_data  = rd_valid_q ? ram_rdata : '0;

  // The RAM is read-first, so a beat read in the same cycle its bin is
  // written sees stale data: S2 covers a 1-cycle spacing, S3 a 2-cycle one.
  // NOTE: every signal gets a default before the if so no latch is inferred.
  always_comb begin
    s1_base = ram_rdata;
    if (s2_valid && (s2_addr == s1_addr))      s1_base = s2_data;
    else if (s3_valid && (s3_addr == s1_addr)) s1_base = s3_data;
  end

  assign s1_inc = CNT_W'(sat_inc(MAX_CNT_W'(s1_base), CNT_W));

  // CLEAR owns the write port; the pipeline is empty whenever CLEAR runs.
  always_comb begin
    ram_we    = s2_valid;
    ram_waddr = s2_addr;
    ram_wdata = s2_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
  end

  hist_bin_ram #(
    .ADDR_W (PIXEL_W),
    .DATA_W (CNT_W)
  ) u_bin_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // NOTE: non-blocking assignments so every stage samples the previous
  // stage's value from before the edge, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s3_addr  <= '0;
      s2_data  <= '0;
      s3_data  <= '0;
    end else begin
      s1_valid <= beat;
      s1_addr  <= s_axis_tdata;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= s1_inc;
      s3_valid <= s2_valid;
      s3_addr  <= s2_addr;
      s3_data  <= s2_data;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      clr_addr      <= '0;
      s_axis_tready <= 1'b0;
      stat_done     <= 1'b0;
      stat_pix_cnt  <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      rd_valid_q <= bin_rd_en && rd_ok;
      case (state)
        ST_IDLE, ST_DONE: begin
          // Clear has priority; a simultaneous start is dropped.
          if (ctrl_clear) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            stat_done <= 1'b0;
          end else if (ctrl_start) begin
            state         <= ST_ACCUM;
            s_axis_tready <= 1'b1;
            stat_done     <= 1'b0;
            stat_pix_cnt  <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + addr_t'(1);
          if (clr_addr == addr_t'(NBINS - 1)) state <= ST_IDLE;
        end
        ST_ACCUM: begin
          if (beat) begin
            stat_pix_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(stat_pix_cnt), CNT_W));
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              state         <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Once S1 is empty the last write is in S2 and commits on this edge.
          if (!s1_valid) begin
            state     <= ST_DONE;
            stat_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
